// File: rtl/gpio_phase_sequencer_if.sv
// Request channel of the GPIO phase sequencer: one stimulus word per valid/ready handshake.
interface gpio_phase_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_gpio;
  logic [WIDTH-1:0] req_use_ext;
  logic [WIDTH-1:0] req_edge;

  modport master (
    output req_valid,
    output req_gpio,
    output req_use_ext,
    output req_edge,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_gpio,
    input  req_use_ext,
    input  req_edge,
    output req_ready
  );
endinterface

// File: rtl/gpio_phase_sequencer.sv
// Applies one GPIO stimulus word per request in five timed phases around a generated ext_clk pulse;
// each bit is updated on accept, before the ext_clk rising edge, or before its falling edge.
module gpio_phase_sequencer #(
  parameter int               WIDTH     = 32,
  parameter int               SETUP_CYC = 2,
  parameter int               HIGH_CYC  = 5,
  parameter int               LOW_CYC   = 5,
  parameter logic [WIDTH-1:0] GPIO_RST  = {WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  gpio_phase_sequencer_if.slave  req,
  output logic [WIDTH-1:0]       gpio,
  output logic                   ext_clk,
  output logic                   busy,
  output logic                   done
);

  localparam int MAX_SH  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int MAX_CYC = (MAX_SH > LOW_CYC) ? MAX_SH : LOW_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP_A = 3'd1,
    SETUP_B = 3'd2,
    HIGH_A  = 3'd3,
    HIGH_B  = 3'd4,
    LOW     = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] cap_gpio_r, cap_gpio_s;
  logic [WIDTH-1:0] cap_use_ext_r, cap_use_ext_s;
  logic [WIDTH-1:0] cap_edge_r, cap_edge_s;
  logic [WIDTH-1:0] gpio_r, gpio_s;
  logic             ext_clk_r, ext_clk_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;

  logic             expire_s;
  logic             ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] rise_mask_s;
  logic [WIDTH-1:0] fall_mask_s;

  // The last LOW cycle also takes a request so the next sequence starts on the done edge.
  assign expire_s    = (cnt_r == CW'(1));
  assign ready_s     = (state_r == IDLE) || ((state_r == LOW) && expire_s);
  assign accept_s    = req.req_valid && ready_s;
  assign rise_mask_s = cap_use_ext_r & cap_edge_r;
  assign fall_mask_s = cap_use_ext_r & ~cap_edge_r;

  assign req.req_ready = ready_s;
  assign gpio          = gpio_r;
  assign ext_clk       = ext_clk_r;
  assign busy          = busy_r;
  assign done          = done_r;

  // Next-state, phase counter and output update logic.
  always_comb begin
    state_s       = state_r;
    cap_gpio_s    = cap_gpio_r;
    cap_use_ext_s = cap_use_ext_r;
    cap_edge_s    = cap_edge_r;
    gpio_s        = gpio_r;
    ext_clk_s     = ext_clk_r;
    done_s        = 1'b0;
    if ((state_r != IDLE) && !expire_s) begin
      cnt_s = cnt_r - CW'(1);
    end else begin
      cnt_s = cnt_r;
    end

    case (state_r)
      IDLE: begin
        state_s = IDLE;
      end
      SETUP_A: begin
        if (expire_s) begin
          gpio_s  = (gpio_r & ~rise_mask_s) | (cap_gpio_r & rise_mask_s);
          cnt_s   = CW'(SETUP_CYC);
          state_s = SETUP_B;
        end else begin
          state_s = SETUP_A;
        end
      end
      SETUP_B: begin
        if (expire_s) begin
          ext_clk_s = 1'b1;
          cnt_s     = CW'(HIGH_CYC);
          state_s   = HIGH_A;
        end else begin
          state_s = SETUP_B;
        end
      end
      HIGH_A: begin
        if (expire_s) begin
          gpio_s  = (gpio_r & ~fall_mask_s) | (cap_gpio_r & fall_mask_s);
          cnt_s   = CW'(HIGH_CYC);
          state_s = HIGH_B;
        end else begin
          state_s = HIGH_A;
        end
      end
      HIGH_B: begin
        if (expire_s) begin
          ext_clk_s = 1'b0;
          cnt_s     = CW'(LOW_CYC);
          state_s   = LOW;
        end else begin
          state_s = HIGH_B;
        end
      end
      LOW: begin
        if (expire_s) begin
          done_s  = 1'b1;
          cnt_s   = {CW{1'b0}};
          state_s = IDLE;
        end else begin
          state_s = LOW;
        end
      end
      default: begin
        cnt_s   = {CW{1'b0}};
        state_s = IDLE;
      end
    endcase

    if (accept_s) begin
      cap_gpio_s    = req.req_gpio;
      cap_use_ext_s = req.req_use_ext;
      cap_edge_s    = req.req_edge;
      gpio_s        = (gpio_r & req.req_use_ext) | (req.req_gpio & ~req.req_use_ext);
      cnt_s         = CW'(SETUP_CYC);
      state_s       = SETUP_A;
    end else begin
      cap_gpio_s    = cap_gpio_s;
    end

    busy_s = (state_s != IDLE);
  end

  // State and registered outputs; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      cap_gpio_r    <= {WIDTH{1'b0}};
      cap_use_ext_r <= {WIDTH{1'b0}};
      cap_edge_r    <= {WIDTH{1'b0}};
      gpio_r        <= GPIO_RST;
      ext_clk_r     <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      cap_gpio_r    <= cap_gpio_s;
      cap_use_ext_r <= cap_use_ext_s;
      cap_edge_r    <= cap_edge_s;
      gpio_r        <= gpio_s;
      ext_clk_r     <= ext_clk_s;
      done_r        <= done_s;
      busy_r        <= busy_s;
    end
  end

endmodule

// File: tb/tb_gpio_phase_sequencer.sv
// Self-checking bench for gpio_phase_sequencer: vector table, directed corner sequences,
// and randomized traffic against a phase-offset reference model.
module tb_gpio_phase_sequencer;
  localparam int          S    = 2;
  localparam int          H    = 5;
  localparam int          L    = 5;
  localparam int          T    = 2*S + 2*H + L;
  localparam logic [31:0] FRST = 32'hC3C3_3C3C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio, f_gpio;
  logic        ext_clk, busy, done, f_ext, f_busy, f_done;

  int n_vec = 0;
  int n_bad = 0;

  gpio_phase_sequencer_if #(.WIDTH(32)) bus ();
  gpio_phase_sequencer_if #(.WIDTH(32)) fbus ();

  gpio_phase_sequencer dut (
    .clk(clk), .rst(rst), .req(bus.slave),
    .gpio(gpio), .ext_clk(ext_clk), .busy(busy), .done(done)
  );

  gpio_phase_sequencer #(.SETUP_CYC(1), .HIGH_CYC(1), .LOW_CYC(1), .GPIO_RST(FRST)) dut_fast (
    .clk(clk), .rst(rst), .req(fbus.slave),
    .gpio(f_gpio), .ext_clk(f_ext), .busy(f_busy), .done(f_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] g, u, e;
    logic [31:0] exp0, exp_s, exp_f;
  } vec_t;
  vec_t vecs [5];

  // reference model state: sequence age in edges since accept
  logic [31:0] m_base, m_g, m_u, m_e;
  int          m_k;
  bit          m_active, m_done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] g, input logic [31:0] u, input logic [31:0] e);
    bus.req_valid   = v;
    bus.req_gpio    = g;
    bus.req_use_ext = u;
    bus.req_edge    = e;
  endtask

  function automatic logic [31:0] exp_gpio();
    logic [31:0] v;
    v = m_base;
    if (m_active) begin
      v = (v & m_u) | (m_g & ~m_u);
      if (m_k >= S) v = (v & ~(m_u & m_e)) | (m_g & m_u & m_e);
      if (m_k >= 2*S + H) v = (v & ~(m_u & ~m_e)) | (m_g & m_u & ~m_e);
    end
    return v;
  endfunction

  function automatic bit exp_ready();
    return !m_active || (m_k == T - 1);
  endfunction

  task automatic model_edge(input bit r, input bit acc, input logic [31:0] g,
                            input logic [31:0] u, input logic [31:0] e);
    logic [31:0] cur;
    if (r) begin
      m_active = 1'b0;
      m_base   = 32'h0;
      m_done   = 1'b0;
    end else begin
      cur    = exp_gpio();
      m_done = m_active && (m_k + 1 == T);
      if (acc) begin
        m_base = cur; m_g = g; m_u = u; m_e = e;
        m_active = 1'b1; m_k = 0;
      end else if (m_active) begin
        m_k++;
        if (m_k >= T) begin
          m_base   = exp_gpio();
          m_active = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] fg [6];
    logic        fe [6];
    logic        fd [6];
    bit          seen;
    bit          rv, rr, acc;
    logic [31:0] rg, ru, re;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFF00_0000, 32'h0000_FFFF, 32'hFF00_FFFF, 32'hFFFF_FFFF};
    vecs[1] = '{32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hA5A5_A5A5, 32'hA0A0_A0A0, 32'h0000_0000};
    vecs[3] = '{32'h1234_5678, 32'h00FF_00FF, 32'h000F_000F, 32'h1200_5600, 32'h1204_5608, 32'h1234_5678};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    fg = '{32'hC3C3_3C3C, 32'h0000_3C3C, 32'h0000_3C3C, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    fe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    fd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    fbus.req_valid = 1'b0; fbus.req_gpio = 32'h0; fbus.req_use_ext = 32'h0; fbus.req_edge = 32'h0;
    step(); step();
    chk("rst_gpio", gpio, 32'h0);
    chk1("rst_ext_clk", ext_clk, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", bus.req_ready, 1'b1);
    chk("rst_fast_gpio", f_gpio, FRST);
    rst = 1'b0;
    step();

    // vector table, one full sequence per entry
    for (int i = 0; i < 5; i++) begin
      chk1("tbl_ready_idle", bus.req_ready, 1'b1);
      drive(1'b1, vecs[i].g, vecs[i].u, vecs[i].e);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      chk("tbl_gpio_e0", gpio, vecs[i].exp0);
      chk1("tbl_busy_e0", busy, 1'b1);
      for (int k = 1; k <= T; k++) begin
        step();
        if (k == S) chk("tbl_gpio_rise", gpio, vecs[i].exp_s);
        if (k == 2*S + H) chk("tbl_gpio_fall", gpio, vecs[i].exp_f);
        chk1("tbl_ext_clk", ext_clk, (k >= 2*S) && (k < 2*S + 2*H));
        chk1("tbl_done", done, k == T);
      end
      chk("tbl_gpio_end", gpio, vecs[i].exp_f);
      chk1("tbl_busy_end", busy, 1'b0);
      chk1("tbl_ready_end", bus.req_ready, 1'b1);
    end

    // back-to-back with valid held high
    drive(1'b1, 32'h1, 32'h0, 32'h0);
    step();
    chk("b2b_gpio1", gpio, 32'h1);
    drive(1'b1, 32'h2, 32'h0, 32'h0);
    for (int k = 1; k < T; k++) begin
      step();
      if (k < T - 1) chk1("b2b_ready_busy", bus.req_ready, 1'b0);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk1("b2b_done1", done, 1'b1);
    chk("b2b_gpio2", gpio, 32'h2);
    chk1("b2b_busy2", busy, 1'b1);
    for (int k = T + 1; k <= 2*T; k++) begin
      step();
      chk1("b2b_done2", done, k == 2*T);
    end
    chk1("b2b_busy_end", busy, 1'b0);

    // request inputs scrambled while busy
    drive(1'b1, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'hFF00_FF00);
    step();
    chk("chg_gpio_e0", gpio, 32'h0000_0F0F);
    for (int k = 1; k <= T; k++) begin
      drive(k < T, $urandom, $urandom, $urandom);
      step();
      if (k < T - 1) chk1("chg_ready", bus.req_ready, 1'b0);
      if (k == S) chk("chg_gpio_rise", gpio, 32'h0F00_0F0F);
      if (k == 2*S + H) chk("chg_gpio_fall", gpio, 32'h0F0F_0F0F);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk1("chg_done", done, 1'b1);
    chk("chg_gpio_end", gpio, 32'h0F0F_0F0F);
    step();

    // reset while ext_clk is high
    drive(1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    for (int k = 1; k <= 6; k++) step();
    chk1("abort_ext_high", ext_clk, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("abort_ext_clk", ext_clk, 1'b0);
    chk("abort_gpio", gpio, 32'h0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", bus.req_ready, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < T + 5; k++) begin
      step();
      if (done) seen = 1'b1;
    end
    chk1("abort_no_done", seen, 1'b0);

    // all phase lengths = 1
    fbus.req_valid = 1'b1; fbus.req_gpio = 32'h0; fbus.req_use_ext = 32'hFFFF_FFFF; fbus.req_edge = 32'hFFFF_0000;
    for (int k = 0; k <= 5; k++) begin
      step();
      fbus.req_valid = 1'b0;
      chk("fast_gpio", f_gpio, fg[k]);
      chk1("fast_ext_clk", f_ext, fe[k]);
      chk1("fast_done", f_done, fd[k]);
    end
    chk1("fast_busy_end", f_busy, 1'b0);

    // randomized traffic against the reference model
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_edge(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 199) == 0);
      rg = $urandom; ru = $urandom; re = $urandom;
      drive(rv, rg, ru, re);
      rst = rr;
      acc = rv && exp_ready();
      step();
      model_edge(rr, acc, rg, ru, re);
      chk("rnd_gpio", gpio, exp_gpio());
      chk1("rnd_ext_clk", ext_clk, m_active && (m_k >= 2*S) && (m_k < 2*S + 2*H));
      chk1("rnd_done", done, m_done);
      chk1("rnd_busy", busy, m_active);
      chk1("rnd_ready", bus.req_ready, exp_ready());
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
